// File: rtl/rf_cmd_pkg.sv
// rf_cmd_pkg: op/function codes, sequencer states and index-to-enable decode
package rf_cmd_pkg;
   typedef enum logic [2:0] {
      OP_LDI = 3'b000, OP_MOV = 3'b001, OP_CLR = 3'b010,
      OP_INC = 3'b011, OP_DEC = 3'b100, OP_SWP = 3'b101
   } op_e;
   typedef enum logic [2:0] {
      FUN_DEC = 3'b000, FUN_INC = 3'b001, FUN_LOAD = 3'b010, FUN_CLEAR = 3'b011
   } fun_e;
   typedef enum logic [2:0] {IDLE, EXEC, SWP1, SWP2, SWP3, DONE} state_e;
   // {RegSel, ScrSel}: index 0 (R1) maps to bit 7, index 7 (S4) to bit 0
   function automatic logic [7:0] sel_decode(input logic [2:0] idx, input logic en);
      logic [7:0] sel;
      sel = 8'hFF;
      if (en) sel[3'd7 - idx] = 1'b0;
      return sel;
   endfunction
endpackage

// File: rtl/rf_cmd_sequencer_if.sv
// rf_cmd_sequencer_if: command handshake plus register-file control/readback bundle
interface rf_cmd_sequencer_if #(parameter int WIDTH = 16);
   logic             CmdValid, CmdReady, CmdDone, CmdErr;
   logic [2:0]       CmdOp, CmdDst, CmdSrc;
   logic [WIDTH-1:0] CmdImm, RfOutA, I;
   logic [3:0]       RegSel, ScrSel;
   logic [2:0]       FunSel, OutASel, OutBSel;
   modport master (
      output CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, RfOutA,
      input  CmdReady, CmdDone, CmdErr, RegSel, ScrSel, FunSel, OutASel, OutBSel, I
   );
   modport slave (
      input  CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, RfOutA,
      output CmdReady, CmdDone, CmdErr, RegSel, ScrSel, FunSel, OutASel, OutBSel, I
   );
endinterface

// File: rtl/rf_sel_decode.sv
// rf_sel_decode: 3-bit register index plus enable to active-low RegSel/ScrSel
module rf_sel_decode
   import rf_cmd_pkg::*;
(
   input  logic [2:0] idx,
   input  logic       en,
   output logic [3:0] reg_sel,
   output logic [3:0] scr_sel
);
   assign {reg_sel, scr_sel} = sel_decode(idx, en);
endmodule

// File: rtl/rf_cmd_sequencer.sv
// rf_cmd_sequencer: expands register-transfer commands into RF control cycles; RF_CMD_COUNT_EN adds CmdCount
module rf_cmd_sequencer
   import rf_cmd_pkg::*;
#(
   parameter int         WIDTH   = 16,
   parameter logic [2:0] TMP_IDX = 3'd7
) (
   input logic              clk,
   input logic              rst_n,
   rf_cmd_sequencer_if.slave bus
`ifdef RF_CMD_COUNT_EN
   , output logic [15:0]    CmdCount
`endif
);
   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d, dst_q, dst_d, src_q, src_d;
   logic [2:0]       fun_q, fun_d, out_a_q, out_a_d, sel_idx_d;
   logic [WIDTH-1:0] imm_q, imm_d, i_q, i_d;
   logic [3:0]       reg_sel_q, reg_sel_d, scr_sel_q, scr_sel_d;
   logic             use_rf_q, use_rf_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
   logic             accept, ill_d, sel_en_d, swp_d;

   assign accept = bus.CmdValid & ready_q;

   always_comb begin
      op_d      = accept ? bus.CmdOp : op_q;
      dst_d     = accept ? bus.CmdDst : dst_q;
      src_d     = accept ? bus.CmdSrc : src_q;
      imm_d     = accept ? bus.CmdImm : imm_q;
      ill_d     = op_d[2:1] == 2'b11 || (op_d == OP_SWP && (dst_d == TMP_IDX || src_d == TMP_IDX));
      state_d   = state_q == IDLE ? (!accept ? IDLE : (op_d == OP_SWP && !ill_d) ? SWP1 : EXEC) :
                  (state_q == EXEC || state_q == SWP3) ? DONE :
                  state_q == SWP1 ? SWP2 : state_q == SWP2 ? SWP3 : IDLE;
      swp_d     = state_d == SWP1 || state_d == SWP2 || state_d == SWP3;
      sel_en_d  = (state_d == EXEC && !ill_d) || swp_d;
      sel_idx_d = state_d == SWP1 ? TMP_IDX : state_d == SWP3 ? src_d : dst_d;
      out_a_d   = state_d == SWP1 ? dst_d : state_d == SWP2 ? src_d : state_d == SWP3 ? TMP_IDX :
                  (state_d == EXEC && op_d == OP_MOV) ? src_d : 3'd0;
      fun_d     = (state_d != EXEC || ill_d) ? FUN_LOAD : op_d == OP_CLR ? FUN_CLEAR :
                  op_d == OP_INC ? FUN_INC : op_d == OP_DEC ? FUN_DEC : FUN_LOAD;
      use_rf_d  = (state_d == EXEC && op_d == OP_MOV) || swp_d;
      i_d       = (state_d == EXEC && op_d == OP_LDI) ? imm_d : '0;
      ready_d   = state_d == IDLE;
      done_d    = state_d == DONE;
      err_d     = state_d == DONE && ill_d;
   end

   rf_sel_decode u_sel (.idx(sel_idx_d), .en(sel_en_d), .reg_sel(reg_sel_d), .scr_sel(scr_sel_d));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         dst_q     <= '0;
         src_q     <= '0;
         imm_q     <= '0;
         fun_q     <= FUN_LOAD;
         out_a_q   <= '0;
         i_q       <= '0;
         use_rf_q  <= 1'b0;
         reg_sel_q <= 4'hF;
         scr_sel_q <= 4'hF;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dst_q     <= dst_d;
         src_q     <= src_d;
         imm_q     <= imm_d;
         fun_q     <= fun_d;
         out_a_q   <= out_a_d;
         i_q       <= i_d;
         use_rf_q  <= use_rf_d;
         reg_sel_q <= reg_sel_d;
         scr_sel_q <= scr_sel_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // moves and swaps forward the readback of the port-A register selected this cycle
   assign bus.I        = use_rf_q ? bus.RfOutA : i_q;
   assign bus.RegSel   = reg_sel_q;
   assign bus.ScrSel   = scr_sel_q;
   assign bus.FunSel   = fun_q;
   assign bus.OutASel  = out_a_q;
   assign bus.OutBSel  = dst_q;
   assign bus.CmdReady = ready_q;
   assign bus.CmdDone  = done_q;
   assign bus.CmdErr   = err_q;

`ifdef RF_CMD_COUNT_EN
   logic [15:0] cnt_q, cnt_d;
   always_comb cnt_d = cnt_q + 16'(done_q & ~err_q);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign CmdCount = cnt_q;
`endif
endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// tb_rf_cmd_sequencer: directed and random commands checked against a register-level reference model
module tb_rf_cmd_sequencer;
   localparam int W = 16;
   localparam logic [2:0] TMP = 3'd7;

   typedef struct {
      logic [2:0]   idx;
      logic [2:0]   fun;
      logic [2:0]   oa;
      logic [W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int errors = 0;
   int unsigned cnt_exp = 0;
   logic [W-1:0] rf [8] = '{default: '0};
   logic [W-1:0] ref_rf [8] = '{default: '0};
   logic [7:0] en_n;

   rf_cmd_sequencer_if #(.WIDTH(W)) bus ();
`ifdef RF_CMD_COUNT_EN
   logic [15:0] cmd_count;
`endif

   rf_cmd_sequencer #(.WIDTH(W), .TMP_IDX(TMP)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef RF_CMD_COUNT_EN
      , .CmdCount(cmd_count)
`endif
   );

   always #5 clk = ~clk;

   // register file behaviour: enables are active low, function selects the update
   assign en_n = {bus.RegSel, bus.ScrSel};
   assign bus.RfOutA = rf[bus.OutASel];
   always @(posedge clk)
      for (int k = 0; k < 8; k++)
         if (!en_n[7-k])
            rf[k] <= bus.FunSel == 3'b000 ? rf[k] - 16'd1 : bus.FunSel == 3'b001 ? rf[k] + 16'd1 :
                     bus.FunSel == 3'b011 ? 16'd0 : bus.I;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"}, en_n, 8'hFF);
      chk({tag, "_fun"}, bus.FunSel, 3'b010);
      chk({tag, "_oa"}, bus.OutASel, 3'd0);
      chk({tag, "_i"}, bus.I, 0);
      chk({tag, "_ready"}, bus.CmdReady, 1);
      chk({tag, "_done"}, bus.CmdDone, 0);
      chk({tag, "_err"}, bus.CmdErr, 0);
   endtask

   task automatic chk_regs();
      for (int k = 0; k < 8; k++) chk($sformatf("reg%0d", k), rf[k], ref_rf[k]);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                          input logic [W-1:0] imm, input bit hold);
      wr_t wq[$];
      logic ill;
      int lat;
      logic [7:0] exp_en;
      logic [W-1:0] t;
      ill = op[2:1] == 2'b11 || (op == 3'd5 && (d == TMP || s == TMP));
      lat = (op == 3'd5 && !ill) ? 4 : 2;
      if (!ill) begin
         if (op == 3'd5) begin
            wq.push_back('{TMP, 3'b010, d, ref_rf[d]});
            wq.push_back('{d, 3'b010, s, ref_rf[s]});
            wq.push_back('{s, 3'b010, TMP, ref_rf[d]});
         end else
            wq.push_back('{d, op == 3'd2 ? 3'b011 : op == 3'd3 ? 3'b001 : op == 3'd4 ? 3'b000 : 3'b010,
                           op == 3'd1 ? s : 3'd0,
                           op == 3'd0 ? imm : op == 3'd1 ? ref_rf[s] : 16'd0});
      end
      @(negedge clk);
      chk("ready_before", bus.CmdReady, 1);
      bus.CmdValid = 1'b1;
      bus.CmdOp = op;
      bus.CmdDst = d;
      bus.CmdSrc = s;
      bus.CmdImm = imm;
      @(posedge clk);
      #1;
      if (hold) begin
         bus.CmdOp = 3'($urandom);
         bus.CmdDst = 3'($urandom);
         bus.CmdSrc = 3'($urandom);
         bus.CmdImm = 16'($urandom);
      end else bus.CmdValid = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         exp_en = 8'hFF;
         if (c <= wq.size()) exp_en[7 - wq[c-1].idx] = 1'b0;
         chk("enables", en_n, exp_en);
         chk("ready_busy", bus.CmdReady, 0);
         chk("done", bus.CmdDone, c == lat);
         chk("err", bus.CmdErr, c == lat && ill);
         chk("outb", bus.OutBSel, d);
         chk("outa", bus.OutASel, c <= wq.size() ? wq[c-1].oa : 3'd0);
         if (c <= wq.size()) begin
            chk("funsel", bus.FunSel, wq[c-1].fun);
            chk("wdata", bus.I, wq[c-1].data);
         end
         if (c == lat) bus.CmdValid = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", bus.CmdDone, 0);
      chk("ready_after", bus.CmdReady, 1);
      if (!ill) begin
         cnt_exp++;
         case (op)
            3'd0: ref_rf[d] = imm;
            3'd1: ref_rf[d] = ref_rf[s];
            3'd2: ref_rf[d] = '0;
            3'd3: ref_rf[d] = ref_rf[d] + 16'd1;
            3'd4: ref_rf[d] = ref_rf[d] - 16'd1;
            default: begin
               t = ref_rf[d];
               ref_rf[TMP] = t;
               ref_rf[d] = ref_rf[s];
               ref_rf[s] = t;
            end
         endcase
      end
      chk_regs();
`ifdef RF_CMD_COUNT_EN
      chk("cmd_count", cmd_count, 16'(cnt_exp));
`endif
   endtask

   initial begin
      bus.CmdValid = 1'b0;
      bus.CmdOp = '0;
      bus.CmdDst = '0;
      bus.CmdSrc = '0;
      bus.CmdImm = '0;
      #1 rst_n = 1'b0;
      #2;
      chk_idle("reset");
      chk("reset_outb", bus.OutBSel, 0);
`ifdef RF_CMD_COUNT_EN
      chk("reset_count", cmd_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      run_cmd(3'd0, 3'd2, 3'd0, 16'hA5A5, 1'b0);
      run_cmd(3'd1, 3'd5, 3'd2, 16'h0000, 1'b0);
      run_cmd(3'd0, 3'd0, 3'd0, 16'h0001, 1'b1);
      run_cmd(3'd0, 3'd1, 3'd0, 16'h0002, 1'b0);
      run_cmd(3'd5, 3'd0, 3'd1, 16'h0000, 1'b0);
      run_cmd(3'd5, 3'd7, 3'd1, 16'h0000, 1'b0);
      run_cmd(3'd5, 3'd2, 3'd7, 16'h0000, 1'b1);
      run_cmd(3'd6, 3'd3, 3'd0, 16'h1234, 1'b0);
      run_cmd(3'd7, 3'd4, 3'd0, 16'h4321, 1'b0);
      run_cmd(3'd5, 3'd3, 3'd3, 16'h0000, 1'b0);
      run_cmd(3'd3, 3'd6, 3'd0, 16'h0000, 1'b0);
      run_cmd(3'd4, 3'd4, 3'd0, 16'h0000, 1'b0);
      run_cmd(3'd2, 3'd2, 3'd0, 16'h0000, 1'b1);
      run_cmd(3'd4, 3'd2, 3'd0, 16'h0000, 1'b0);
      // abort a swap in its second cycle: only the temp write has landed
      @(negedge clk);
      bus.CmdValid = 1'b1;
      bus.CmdOp = 3'd5;
      bus.CmdDst = 3'd1;
      bus.CmdSrc = 3'd2;
      @(posedge clk);
      #1 bus.CmdValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("swp2_en", en_n, 8'hBF);
      chk("swp2_oa", bus.OutASel, 3'd2);
      rst_n = 1'b0;
      #1;
      chk_idle("abort");
      ref_rf[TMP] = ref_rf[1];
      cnt_exp = 0;
      @(negedge clk);
      chk_idle("abort_hold");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_release", bus.CmdReady, 1);
      chk_regs();
      for (int n = 0; n < 60; n++)
         run_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom), 1'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
